// File: rtl/rs_alu_pkg.sv
// rs_alu_pkg: shared widths, opcodes and entry/broadcast types for the ALU reservation station.
// Optional feature macro: RS_OLDEST_FIRST_EN (oldest-first dispatch selection).
package rs_alu_pkg;
    localparam int ROB_POS_WID = 4;
    localparam int DATA_WID    = 32;
    localparam int ADDR_WID    = 32;
    localparam int OPCODE_WID  = 7;
    localparam int FUNCT3_WID  = 3;
    localparam int RS_SIZE     = 16;
    localparam int RS_IDX_WID  = 4;

    localparam logic [OPCODE_WID-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_WID-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WID-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_WID-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_WID-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WID-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WID-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_WID-1:0] OP_ARITHI = 7'b0010011;
    localparam logic [OPCODE_WID-1:0] OP_ARITH  = 7'b0110011;

    typedef struct packed {
        logic                   rdy;
        logic [DATA_WID-1:0]    val;
        logic [ROB_POS_WID-1:0] tag;
    } src_t;

    typedef struct packed {
        logic                   valid;
        logic [ROB_POS_WID-1:0] tag;
        logic [DATA_WID-1:0]    val;
    } cdb_t;

    typedef struct packed {
        logic                   busy;
        logic [OPCODE_WID-1:0]  opcode;
        logic [FUNCT3_WID-1:0]  funct3;
        logic                   funct7;
        src_t                   s1;
        src_t                   s2;
        logic [DATA_WID-1:0]    imm;
        logic [ADDR_WID-1:0]    pc;
        logic [ROB_POS_WID-1:0] rob_pos;
    } entry_t;

    typedef struct packed {
        logic                   alu_en;
        logic [OPCODE_WID-1:0]  opcode;
        logic [FUNCT3_WID-1:0]  funct3;
        logic                   funct7;
        logic [DATA_WID-1:0]    val1;
        logic [DATA_WID-1:0]    val2;
        logic [DATA_WID-1:0]    imm;
        logic [ADDR_WID-1:0]    pc;
        logic [ROB_POS_WID-1:0] rob_pos;
    } disp_t;

    // ALU bus is checked first so it wins if both buses carry the same tag.
    function automatic src_t snoop(src_t s, cdb_t a, cdb_t l);
        src_t r;
        r = s;
        if (!s.rdy && a.valid && a.tag == s.tag) begin
            r.rdy = 1'b1;
            r.val = a.val;
        end else if (!s.rdy && l.valid && l.tag == s.tag) begin
            r.rdy = 1'b1;
            r.val = l.val;
        end
        return r;
    endfunction
endpackage

// File: rtl/rs_pick.sv
// rs_pick: combinational selector over the ready vector; lowest index wins,
// or smallest ROB distance from rob_head when RS_OLDEST_FIRST_EN is defined.
module rs_pick
    import rs_alu_pkg::*;
(
    input  logic [RS_SIZE-1:0]                  ready_i,
`ifdef RS_OLDEST_FIRST_EN
    input  logic [RS_SIZE-1:0][ROB_POS_WID-1:0] rob_pos_i,
    input  logic [ROB_POS_WID-1:0]              rob_head_i,
`endif
    output logic                                valid_o,
    output logic [RS_IDX_WID-1:0]               idx_o
);
    logic                  found;
    logic [RS_IDX_WID-1:0] idx;
`ifdef RS_OLDEST_FIRST_EN
    logic [ROB_POS_WID-1:0] best;
    logic [ROB_POS_WID-1:0] dist;
    // Modular distance from the ROB head orders entries by age across wrap.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '1;
        dist  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            dist = rob_pos_i[i] - rob_head_i;
            if (ready_i[i] && (!found || dist < best)) begin
                found = 1'b1;
                idx   = RS_IDX_WID'(i);
                best  = dist;
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                found = 1'b1;
                idx   = RS_IDX_WID'(i);
            end
        end
    end
`endif
    assign valid_o = found;
    assign idx_o   = idx;
endmodule

// File: rtl/rs_alu.sv
// rs_alu: integer ALU reservation station; holds renamed ops, snoops ALU/LSB broadcasts,
// dispatches one ready op per cycle. RS_OLDEST_FIRST_EN adds rob_head and age-ordered selection.
module rs_alu
    import rs_alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback,
    output logic                   rs_full,
    input  logic                   issue,
    input  logic [OPCODE_WID-1:0]  issue_opcode,
    input  logic [FUNCT3_WID-1:0]  issue_funct3,
    input  logic                   issue_funct7,
    input  logic                   issue_rs1_rdy,
    input  logic [DATA_WID-1:0]    issue_rs1_val,
    input  logic [ROB_POS_WID-1:0] issue_rs1_rob,
    input  logic                   issue_rs2_rdy,
    input  logic [DATA_WID-1:0]    issue_rs2_val,
    input  logic [ROB_POS_WID-1:0] issue_rs2_rob,
    input  logic [DATA_WID-1:0]    issue_imm,
    input  logic [ADDR_WID-1:0]    issue_pc,
    input  logic [ROB_POS_WID-1:0] issue_rob_pos,
    input  logic                   alu_result,
    input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
    input  logic [DATA_WID-1:0]    alu_result_val,
    input  logic                   lsb_result,
    input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
    input  logic [DATA_WID-1:0]    lsb_result_val,
`ifdef RS_OLDEST_FIRST_EN
    input  logic [ROB_POS_WID-1:0] rob_head,
`endif
    output logic                   alu_en,
    output logic [OPCODE_WID-1:0]  opcode,
    output logic [FUNCT3_WID-1:0]  funct3,
    output logic                   funct7,
    output logic [DATA_WID-1:0]    val1,
    output logic [DATA_WID-1:0]    val2,
    output logic [DATA_WID-1:0]    imm,
    output logic [ADDR_WID-1:0]    pc,
    output logic [ROB_POS_WID-1:0] rob_pos
);
    localparam int CW = RS_IDX_WID + 1;

    entry_t                ent_q [RS_SIZE];
    entry_t                ent_d [RS_SIZE];
    disp_t                 out_q;
    disp_t                 out_d;
    logic [RS_SIZE-1:0]    ready;
    logic                  pick_valid;
    logic [RS_IDX_WID-1:0] pick_idx;
    logic                  free_valid;
    logic [RS_IDX_WID-1:0] free_idx;
    logic [CW-1:0]         free_cnt;
    cdb_t                  alu_cdb;
    cdb_t                  lsb_cdb;

    assign alu_cdb = cdb_t'{valid: alu_result, tag: alu_result_rob_pos, val: alu_result_val};
    assign lsb_cdb = cdb_t'{valid: lsb_result, tag: lsb_result_rob_pos, val: lsb_result_val};

`ifdef RS_OLDEST_FIRST_EN
    logic [RS_SIZE-1:0][ROB_POS_WID-1:0] tags;
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) tags[i] = ent_q[i].rob_pos;
    end
`endif

    always_comb begin
        ready      = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        free_cnt   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            ready[i] = ent_q[i].busy & ent_q[i].s1.rdy & ent_q[i].s2.rdy;
            if (!ent_q[i].busy) begin
                free_valid = 1'b1;
                free_idx   = RS_IDX_WID'(i);
                free_cnt   = free_cnt + CW'(1);
            end
        end
    end

    // Full at one free slot so an issue already in flight from the decoder still fits.
    assign rs_full = free_cnt <= CW'(1);

    rs_pick u_pick (
        .ready_i    (ready),
`ifdef RS_OLDEST_FIRST_EN
        .rob_pos_i  (tags),
        .rob_head_i (rob_head),
`endif
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    always_comb begin
        ent_d        = ent_q;
        out_d        = out_q;
        out_d.alu_en = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_q[i].busy) begin
                ent_d[i].s1 = snoop(ent_q[i].s1, alu_cdb, lsb_cdb);
                ent_d[i].s2 = snoop(ent_q[i].s2, alu_cdb, lsb_cdb);
            end
        end
        if (pick_valid) begin
            ent_d[pick_idx].busy = 1'b0;
            out_d = disp_t'{
                alu_en:  1'b1,
                opcode:  ent_q[pick_idx].opcode,
                funct3:  ent_q[pick_idx].funct3,
                funct7:  ent_q[pick_idx].funct7,
                val1:    ent_q[pick_idx].s1.val,
                val2:    ent_q[pick_idx].s2.val,
                imm:     ent_q[pick_idx].imm,
                pc:      ent_q[pick_idx].pc,
                rob_pos: ent_q[pick_idx].rob_pos
            };
        end
        if (issue && free_valid) begin
            ent_d[free_idx] = entry_t'{
                busy:    1'b1,
                opcode:  issue_opcode,
                funct3:  issue_funct3,
                funct7:  issue_funct7,
                s1:      snoop(src_t'{rdy: issue_rs1_rdy, val: issue_rs1_val, tag: issue_rs1_rob}, alu_cdb, lsb_cdb),
                s2:      snoop(src_t'{rdy: issue_rs2_rdy, val: issue_rs2_val, tag: issue_rs2_rob}, alu_cdb, lsb_cdb),
                imm:     issue_imm,
                pc:      issue_pc,
                rob_pos: issue_rob_pos
            };
        end
        if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
            out_d.alu_en = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '{default: '0};
            out_q <= '0;
        end else if (rdy) begin
            ent_q <= ent_d;
            out_q <= out_d;
        end
    end

    assign alu_en  = out_q.alu_en;
    assign opcode  = out_q.opcode;
    assign funct3  = out_q.funct3;
    assign funct7  = out_q.funct7;
    assign val1    = out_q.val1;
    assign val2    = out_q.val2;
    assign imm     = out_q.imm;
    assign pc      = out_q.pc;
    assign rob_pos = out_q.rob_pos;
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed stimulus for rs_alu; expected dispatches are queued at issue time
// and a negedge monitor pops and compares each new dispatch including its cycle.
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        rs_full;
    logic        issue = 1'b0;
    logic [6:0]  issue_opcode = '0;
    logic [2:0]  issue_funct3 = '0;
    logic        issue_funct7 = 1'b0;
    logic        issue_rs1_rdy = 1'b0;
    logic [31:0] issue_rs1_val = '0;
    logic [3:0]  issue_rs1_rob = '0;
    logic        issue_rs2_rdy = 1'b0;
    logic [31:0] issue_rs2_val = '0;
    logic [3:0]  issue_rs2_rob = '0;
    logic [31:0] issue_imm = '0;
    logic [31:0] issue_pc = '0;
    logic [3:0]  issue_rob_pos = '0;
    logic        alu_result = 1'b0;
    logic [3:0]  alu_result_rob_pos = '0;
    logic [31:0] alu_result_val = '0;
    logic        lsb_result = 1'b0;
    logic [3:0]  lsb_result_rob_pos = '0;
    logic [31:0] lsb_result_val = '0;
    logic        alu_en;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] val1, val2, imm, pc;
    logic [3:0]  rob_pos;

    rs_alu dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rs_full(rs_full),
        .issue(issue), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
        .issue_funct7(issue_funct7), .issue_rs1_rdy(issue_rs1_rdy),
        .issue_rs1_val(issue_rs1_val), .issue_rs1_rob(issue_rs1_rob),
        .issue_rs2_rdy(issue_rs2_rdy), .issue_rs2_val(issue_rs2_val),
        .issue_rs2_rob(issue_rs2_rob), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rob_pos(issue_rob_pos), .alu_result(alu_result),
        .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
        .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
        .lsb_result_val(lsb_result_val),
`ifdef RS_OLDEST_FIRST_EN
        .rob_head(4'd0),
`endif
        .alu_en(alu_en), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] im;
        logic [31:0] p;
        logic [3:0]  rp;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   occ = 0;
    logic rst_s = 1'b1;
    logic rdy_s = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A dispatch is new only if the edge that produced it was enabled.
    always @(negedge clk) begin
        if (!rst_s && rdy_s && alu_en) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dispatch: rob_pos=%0d val1=0x%0h at cycle %0d, none expected", rob_pos, val1, cyc);
            end else begin
                e_mon = q.pop_front();
                occ--;
                chk("disp_cycle", 32'(cyc), 32'(e_mon.cyc));
                chk("disp_rob_pos", 32'(rob_pos), 32'(e_mon.rp));
                chk("disp_opcode", 32'(opcode), 32'(e_mon.op));
                chk("disp_funct", {28'd0, funct7, funct3}, {28'd0, e_mon.f7, e_mon.f3});
                chk("disp_val1", val1, e_mon.v1);
                chk("disp_val2", val2, e_mon.v2);
                chk("disp_imm", imm, e_mon.im);
                chk("disp_pc", pc, e_mon.p);
            end
        end
        rst_s = rst;
        rdy_s = rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input int c, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] im,
                        input logic [31:0] p, input logic [3:0] rp);
        exp_t x;
        x.cyc = c; x.op = op; x.f3 = f3; x.f7 = f7;
        x.v1 = v1; x.v2 = v2; x.im = im; x.p = p; x.rp = rp;
        q.push_back(x);
    endtask

    task automatic do_issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                            input logic [31:0] im, input logic [31:0] p, input logic [3:0] rp,
                            output int e);
        chk("issue_has_free_entry", 32'(occ < RS_SIZE), 32'd1);
        issue = 1'b1; issue_opcode = op; issue_funct3 = f3; issue_funct7 = f7;
        issue_rs1_rdy = r1; issue_rs1_val = v1; issue_rs1_rob = t1;
        issue_rs2_rdy = r2; issue_rs2_val = v2; issue_rs2_rob = t2;
        issue_imm = im; issue_pc = p; issue_rob_pos = rp;
        tick();
        e = cyc;
        occ++;
        issue = 1'b0;
    endtask

    int e;
    int b;

    initial begin
        idle(3);
        chk("reset_alu_en", 32'(alu_en), 32'd0);
        chk("reset_rs_full", 32'(rs_full), 32'd0);
        chk("reset_val1", val1, 32'd0);
        chk("reset_rob_pos", 32'(rob_pos), 32'd0);
        chk("reset_pc", pc, 32'd0);
        rst = 1'b0;
        tick();

        // both operands ready: dispatch one edge after issue, back-to-back
        do_issue(OP_ARITH, 3'd0, 1'b0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 32'd0, 32'h1000, 4'd3, e);
        push(e + 1, OP_ARITH, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h1000, 4'd3);
        do_issue(OP_ARITH, 3'd0, 1'b1, 1'b1, 32'd10, 4'd0, 1'b1, 32'd3, 4'd0, 32'd0, 32'h1004, 4'd4, e);
        push(e + 1, OP_ARITH, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 32'h1004, 4'd4);
        idle(3);

        // rs1 waits on tag 6, ALU broadcasts it two cycles later
        do_issue(OP_ARITHI, 3'd2, 1'b0, 1'b0, 32'd0, 4'd6, 1'b1, 32'd1, 4'd0, 32'h7, 32'h2000, 4'd7, e);
        push(e + 3, OP_ARITHI, 3'd2, 1'b0, 32'h1234, 32'd1, 32'h7, 32'h2000, 4'd7);
        tick();
        alu_result = 1'b1; alu_result_rob_pos = 4'd6; alu_result_val = 32'h1234;
        tick();
        alu_result = 1'b0;
        idle(3);

        // LSB broadcast of rs2's tag in the issue cycle is captured at issue
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd9; lsb_result_val = 32'hDEAD;
        do_issue(OP_ARITH, 3'd7, 1'b0, 1'b1, 32'h11, 4'd0, 1'b0, 32'd0, 4'd9, 32'd0, 32'h3000, 4'd8, e);
        lsb_result = 1'b0;
        push(e + 1, OP_ARITH, 3'd7, 1'b0, 32'h11, 32'hDEAD, 32'd0, 32'h3000, 4'd8);
        idle(3);

        // both buses carry the same tag: ALU value wins
        do_issue(OP_ARITH, 3'd4, 1'b0, 1'b0, 32'd0, 4'd2, 1'b1, 32'h22, 4'd0, 32'd0, 32'h4000, 4'd10, e);
        alu_result = 1'b1; alu_result_rob_pos = 4'd2; alu_result_val = 32'hA;
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd2; lsb_result_val = 32'hB;
        push(e + 2, OP_ARITH, 3'd4, 1'b0, 32'hA, 32'h22, 32'd0, 32'h4000, 4'd10);
        tick();
        alu_result = 1'b0; lsb_result = 1'b0;
        idle(3);

        // fill all 16 entries waiting on tag 5; rs_full rises with one slot left
        for (int i = 0; i < RS_SIZE; i++) begin
            do_issue(OP_ARITHI, 3'd0, 1'b0, 1'b0, 32'd0, 4'd5, 1'b1, 32'(i), 4'd0,
                     32'(i), 32'h100 + 32'(4 * i), 4'(i), e);
            if (i == 13) chk("rs_full_two_free", 32'(rs_full), 32'd0);
            if (i >= 14) chk("rs_full_le_one_free", 32'(rs_full), 32'd1);
        end
        alu_result = 1'b1; alu_result_rob_pos = 4'd5; alu_result_val = 32'h55;
        tick();
        b = cyc;
        alu_result = 1'b0;
        for (int i = 0; i < RS_SIZE; i++)
            push(b + 1 + i, OP_ARITHI, 3'd0, 1'b0, 32'h55, 32'(i), 32'(i), 32'h100 + 32'(4 * i), 4'(i));
        idle(18);
        chk("rs_full_after_drain", 32'(rs_full), 32'd0);

        // rollback flushes waiting entries and discards a same-cycle issue
        do_issue(OP_ARITH, 3'd0, 1'b0, 1'b1, 32'd2, 4'd0, 1'b1, 32'd3, 4'd0, 32'd0, 32'h5000, 4'd1, e);
        push(e + 1, OP_ARITH, 3'd0, 1'b0, 32'd2, 32'd3, 32'd0, 32'h5000, 4'd1);
        do_issue(OP_ARITH, 3'd0, 1'b0, 1'b0, 32'd0, 4'd12, 1'b1, 32'd1, 4'd0, 32'd0, 32'h5004, 4'd2, e);
        do_issue(OP_ARITH, 3'd0, 1'b0, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd13, 32'd0, 32'h5008, 4'd3, e);
        do_issue(OP_ARITH, 3'd0, 1'b0, 1'b0, 32'd0, 4'd14, 1'b0, 32'd0, 4'd15, 32'd0, 32'h500C, 4'd5, e);
        rollback = 1'b1;
        do_issue(OP_ARITH, 3'd0, 1'b0, 1'b1, 32'd4, 4'd0, 1'b1, 32'd5, 4'd0, 32'd0, 32'h5010, 4'd9, e);
        rollback = 1'b0;
        occ = 0;
        chk("rollback_alu_en", 32'(alu_en), 32'd0);
        chk("rollback_rs_full", 32'(rs_full), 32'd0);
        alu_result = 1'b1; alu_result_rob_pos = 4'd12; alu_result_val = 32'h1;
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd13; lsb_result_val = 32'h2;
        tick();
        alu_result_rob_pos = 4'd14; lsb_result_rob_pos = 4'd15;
        tick();
        alu_result = 1'b0; lsb_result = 1'b0;
        idle(4);
        do_issue(OP_ARITH, 3'd5, 1'b0, 1'b1, 32'd6, 4'd0, 1'b1, 32'd7, 4'd0, 32'd0, 32'h5020, 4'd6, e);
        push(e + 1, OP_ARITH, 3'd5, 1'b0, 32'd6, 32'd7, 32'd0, 32'h5020, 4'd6);
        idle(3);

        // rdy low freezes a ready entry, then freezes the output registers
        do_issue(OP_ARITH, 3'd1, 1'b0, 1'b1, 32'h77, 4'd0, 1'b1, 32'h88, 4'd0, 32'd0, 32'h6000, 4'd11, e);
        push(e + 4, OP_ARITH, 3'd1, 1'b0, 32'h77, 32'h88, 32'd0, 32'h6000, 4'd11);
        rdy = 1'b0;
        repeat (3) begin
            tick();
            chk("freeze_no_dispatch", 32'(alu_en), 32'd0);
        end
        rdy = 1'b1;
        tick();
        chk("resume_dispatch", 32'(alu_en), 32'd1);
        chk("resume_rob_pos", 32'(rob_pos), 32'd11);
        rdy = 1'b0;
        tick();
        chk("freeze_hold_alu_en", 32'(alu_en), 32'd1);
        chk("freeze_hold_val2", val2, 32'h88);
        rdy = 1'b1;
        tick();
        chk("idle_alu_en", 32'(alu_en), 32'd0);

        for (int k = 0; k < 50 && q.size() > 0; k++) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
